elem_mod_subtractor: RTL and testbench

Streaming modular subtractor for the FHE vector ALU. It computes out = (op1 − op2) mod p element by element over a vector. Operands are lazily reduced in [0, 2p) and the result is fully reduced in [0, p). It is the subtraction counterpart of the element adder and shares the same 5-cycle latency, so the ALU can select between the two without re-timing. Unlike the adder, it has valid/ready backpressure on both sides, an internal output buffer with credit-based input throttling, and an optional vector-length checker.

---
 rtl/fhe_alu_pkg.sv | 12 +
 rtl/elem_sub_out_fifo.sv | 75 +++++++
 rtl/elem_mod_subtractor.sv | 143 ++++++++++++++
 tb/tb_elem_mod_subtractor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_alu_pkg.sv
// Shared FHE vector ALU constants: element width and the common add/sub pipeline latency.
package fhe_alu_pkg;

   localparam int FSIZE            = 32;
   localparam int ELEM_SUB_LATENCY = 5;

   typedef struct packed {
      logic             last;
      logic [FSIZE-1:0] data;
   } elem_t;

endpackage

// File: rtl/elem_sub_out_fifo.sv
// In-order output buffer with a registered head word; a write in cycle n is visible at the head in cycle n+1.
module elem_sub_out_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    mem_cnt;
   logic             head_valid;
   logic [WIDTH-1:0] head;

   logic pop;
   logic load;
   logic from_mem;
   logic bypass;
   logic mem_wr;

   assign pop      = rd_en && head_valid;
   assign load     = !head_valid || pop;
   assign from_mem = load && (mem_cnt != '0);
   // An empty buffer forwards the write straight into the head register.
   assign bypass   = load && (mem_cnt == '0) && wr_en;
   assign mem_wr   = wr_en && !bypass;

   always_ff @(posedge clk) begin
      if (mem_wr && !rst)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_cnt    <= '0;
         head_valid <= 1'b0;
         head       <= '0;
      end else begin
         if (mem_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (from_mem)
            rd_ptr <= rd_ptr + 1'b1;
         mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(from_mem);
         if (from_mem) begin
            head       <= mem[rd_ptr];
            head_valid <= 1'b1;
         end else if (bypass) begin
            head       <= wr_data;
            head_valid <= 1'b1;
         end else if (pop) begin
            head_valid <= 1'b0;
         end
      end
   end

   assign rd_data = head;
   assign count   = mem_cnt + CW'(head_valid);
   assign full    = (count == CW'(DEPTH));
   assign empty   = !head_valid;

endmodule

// File: rtl/elem_mod_subtractor.sv
// Streaming (op1 - op2) mod p with 5-cycle latency, credit-throttled output buffer.
// ELEM_SUB_LEN_CHECK_EN enables the vector-length checker driving len_err.
module elem_mod_subtractor
   import fhe_alu_pkg::*;
#(
   parameter int ID        = 0,
   parameter int OUT_DEPTH = 8,
   parameter int VEC_LEN   = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [FSIZE-1:0] op1,
   input  logic [FSIZE-1:0] op2,
   input  logic [FSIZE-1:0] p,
   output logic [FSIZE-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             len_err
);

   localparam int CW = $clog2(OUT_DEPTH) + 1;
   localparam int SW = CW + 1;

   // ID is a debug tag only; it takes part in the parameter sanity check.
   if (OUT_DEPTH < ELEM_SUB_LATENCY || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 ||
       VEC_LEN < 1 || ID < 0) begin : g_bad_cfg
      $error("elem_mod_subtractor: unsupported parameter set");
   end

   logic             accept;
   logic [FSIZE-1:0] two_p;

   logic             s1_v, s1_last;
   logic [FSIZE-1:0] s1_d;
   logic             s2_v, s2_last, s2_c1;
   logic [FSIZE-1:0] s2_d;
   logic             s3_v, s3_last;
   logic [FSIZE-1:0] s3_r1;
   logic             s4_v, s4_last, s4_c2;
   logic [FSIZE-1:0] s4_r1;
   logic [FSIZE-1:0] r2;

   elem_t            wr_elem;
   elem_t            head_elem;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [2:0]       inflight;
   logic [SW-1:0]    committed;

   assign accept = in_valid && in_ready;
   assign two_p  = {p[FSIZE-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v  <= 1'b0; s1_last <= 1'b0; s1_d  <= '0;
         s2_v  <= 1'b0; s2_last <= 1'b0; s2_d  <= '0; s2_c1 <= 1'b0;
         s3_v  <= 1'b0; s3_last <= 1'b0; s3_r1 <= '0;
         s4_v  <= 1'b0; s4_last <= 1'b0; s4_r1 <= '0; s4_c2 <= 1'b0;
      end else begin
         // Adding 2p first keeps the difference non-negative for lazily reduced operands.
         s1_v    <= accept;
         s1_last <= in_last;
         s1_d    <= op1 + two_p - op2;

         s2_v    <= s1_v;
         s2_last <= s1_last;
         s2_d    <= s1_d;
         s2_c1   <= (s1_d >= two_p);

         s3_v    <= s2_v;
         s3_last <= s2_last;
         s3_r1   <= s2_c1 ? (s2_d - two_p) : s2_d;

         s4_v    <= s3_v;
         s4_last <= s3_last;
         s4_r1   <= s3_r1;
         s4_c2   <= (s3_r1 >= p);
      end
   end

   assign r2      = s4_c2 ? (s4_r1 - p) : s4_r1;
   assign wr_elem = '{last: s4_last, data: r2};

   elem_sub_out_fifo #(
      .WIDTH ($bits(elem_t)),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s4_v),
      .wr_data (wr_elem),
      .rd_en   (out_ready),
      .rd_data (head_elem),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out       = head_elem.data;
   assign out_last  = head_elem.last;
   assign out_valid = !fifo_empty;

   // Credits use only registered occupancy, so a pop frees its slot one cycle later.
   assign inflight  = 3'(s1_v) + 3'(s2_v) + 3'(s3_v) + 3'(s4_v);
   assign committed = SW'(fifo_count) + SW'(inflight);
   assign in_ready  = !rst && (committed < SW'(OUT_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst)
         a_no_overflow: assert (!(s4_v && fifo_full));
   end

`ifdef ELEM_SUB_LEN_CHECK_EN
   localparam int NW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   logic [NW-1:0] elem_cnt;
   logic          at_end;
   logic          len_err_q;

   assign at_end = (elem_cnt == NW'(VEC_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         elem_cnt  <= '0;
         len_err_q <= 1'b0;
      end else if (accept) begin
         elem_cnt <= (in_last || at_end) ? '0 : elem_cnt + 1'b1;
         if (in_last != at_end)
            len_err_q <= 1'b1;
      end
   end

   assign len_err = len_err_q;
`else
   assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_elem_mod_subtractor.sv
// Directed and random checks for elem_mod_subtractor with p = 17, OUT_DEPTH = 8, VEC_LEN = 4.
module tb_elem_mod_subtractor;
   import fhe_alu_pkg::*;

   localparam int DEPTH = 8;
   localparam int VLEN  = 4;
   localparam int P     = 17;
`ifdef ELEM_SUB_LEN_CHECK_EN
   localparam bit EXP_ERR = 1'b1;
`else
   localparam bit EXP_ERR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             out_ready = 1'b1;
   logic [FSIZE-1:0] op1 = '0;
   logic [FSIZE-1:0] op2 = '0;
   logic [FSIZE-1:0] p = FSIZE'(P);
   logic [FSIZE-1:0] out;
   logic             in_ready, out_valid, out_last, len_err;

   logic [FSIZE-1:0] cur_exp = '0;
   int               n_assert = 0;
   int               n_fail = 0;
   int               cycle = 0;
   int               delivered = 0;
   bit               lat_chk = 1'b0;

   typedef struct {
      logic [FSIZE-1:0] val;
      logic             last;
      int               t;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int               a;
      int               b;
      bit               last;
      logic [FSIZE-1:0] exp;
   } vec_t;
   vec_t tbl[7];

   elem_mod_subtractor #(.ID(3), .OUT_DEPTH(DEPTH), .VEC_LEN(VLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .op1(op1), .op2(op2), .p(p), .out(out), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .len_err(len_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [FSIZE-1:0] model(input int a, input int b);
      int s;
      s = (a - b) % P;
      if (s < 0) s += P;
      return FSIZE'(s);
   endfunction

   // Scoreboard: record accepts, compare deliveries, optionally check 5-cycle latency.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready)
            sb.push_back('{cur_exp, in_last, cycle});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("out_without_pending", 64'(out_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               chk("out_data", 64'(out), 64'(e.val));
               chk("out_last", 64'(out_last), 64'(e.last));
               if (lat_chk) chk("latency", 64'(cycle - e.t), 64'(5));
               delivered++;
            end
         end
      end
   end

   task automatic send(input int a, input int b, input bit last, input logic [FSIZE-1:0] exp);
      op1 = FSIZE'(a); op2 = FSIZE'(b); in_last = last; cur_exp = exp; in_valid = 1'b1;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) break;
      end
      chk("drain_pending", 64'(sb.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, t0, idx;
      tbl[0] = '{5, 3, 1'b0, 2};
      tbl[1] = '{3, 5, 1'b0, 15};
      tbl[2] = '{33, 0, 1'b0, 16};
      tbl[3] = '{0, 33, 1'b0, 1};
      tbl[4] = '{20, 20, 1'b0, 0};
      tbl[5] = '{32, 1, 1'b0, 14};
      tbl[6] = '{16, 33, 1'b1, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out", 64'(out), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_len_err", 64'(len_err), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // Directed vectors, one at a time into an empty pipeline.
      lat_chk = 1'b1;
      d0 = delivered;
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].exp);
         drain();
      end
      chk("table_delivered", 64'(delivered - d0), 64'(7));

      // Random back-to-back stream at full rate.
      d0 = delivered;
      t0 = cycle;
      for (int i = 0; i < 1000; i++) begin
         int a, b;
         a = int'($urandom_range(0, 2 * P - 1));
         b = int'($urandom_range(0, 2 * P - 1));
         send(a, b, 1'b0, model(a, b));
      end
      chk("throughput_cycles", 64'(cycle - t0), 64'(1000));
      drain();
      chk("random_delivered", 64'(delivered - d0), 64'(1000));

      // Backpressure: credits must stop accepts at exactly DEPTH.
      lat_chk = 1'b0;
      do_reset();
      out_ready = 1'b0;
      d0 = delivered;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         op1 = FSIZE'(idx + 10); op2 = FSIZE'((idx * 3) % 34);
         cur_exp = model(idx + 10, (idx * 3) % 34); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_accepts", 64'(idx), 64'(DEPTH));
      @(negedge clk);
      chk("bp_stall_valid", 64'(out_valid), 64'(1));
      chk("bp_stall_out", 64'(out), 64'(model(10, 0)));
      chk("bp_stall_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && idx < 12; c++) begin
         op1 = FSIZE'(idx + 10); op2 = FSIZE'((idx * 3) % 34);
         cur_exp = model(idx + 10, (idx * 3) % 34); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_offered", 64'(idx), 64'(12));
      drain();
      chk("bp_delivered", 64'(delivered - d0), 64'(12));

      // Reset after 3 accepts: nothing in flight survives.
      lat_chk = 1'b1;
      send(9, 1, 1'b0, model(9, 1));
      send(9, 2, 1'b0, model(9, 2));
      send(9, 3, 1'b0, model(9, 3));
      d0 = delivered;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rst_no_out", 64'(out_valid), 64'(0));
      end
      @(posedge clk); #1;
      send(7, 2, 1'b0, 5);
      drain();
      chk("rst_after_delivered", 64'(delivered - d0), 64'(1));

      // Length checker: short vector, correct vector, missing last.
      do_reset();
      send(1, 1, 1'b0, 0);
      send(1, 1, 1'b0, 0);
      @(negedge clk);
      chk("len_ok_midvec", 64'(len_err), 64'(0));
      @(posedge clk); #1;
      send(1, 1, 1'b1, 0);
      @(negedge clk);
      chk("len_short_rise", 64'(len_err), 64'(EXP_ERR));
      repeat (3) @(negedge clk);
      chk("len_short_sticky", 64'(len_err), 64'(EXP_ERR));
      @(posedge clk); #1;
      drain();

      do_reset();
      for (int i = 0; i < VLEN; i++) send(4, i, (i == VLEN - 1), model(4, i));
      drain();
      chk("len_exact_ok", 64'(len_err), 64'(0));

      for (int i = 0; i < VLEN - 1; i++) send(2, 1, 1'b0, 1);
      @(negedge clk);
      chk("len_before_wrap", 64'(len_err), 64'(0));
      @(posedge clk); #1;
      send(2, 1, 1'b0, 1);
      @(negedge clk);
      chk("len_missing_last", 64'(len_err), 64'(EXP_ERR));
      @(posedge clk); #1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
